// File: rtl/key_entry_pkg.sv
// Shared keypad definitions: key codes, scan "no key" marker and the entry FSM
// state encoding used by key_entry and control_game.
package key_entry_pkg;

  typedef logic [3:0] key_t;

  localparam key_t KEY_0    = 4'd0;
  localparam key_t KEY_1    = 4'd1;
  localparam key_t KEY_2    = 4'd2;
  localparam key_t KEY_3    = 4'd3;
  localparam key_t KEY_4    = 4'd4;
  localparam key_t KEY_5    = 4'd5;
  localparam key_t KEY_6    = 4'd6;
  localparam key_t KEY_7    = 4'd7;
  localparam key_t KEY_8    = 4'd8;
  localparam key_t KEY_9    = 4'd9;
  localparam key_t KEY_A    = 4'd10;
  localparam key_t KEY_B    = 4'd11;
  localparam key_t KEY_C    = 4'd12;
  localparam key_t KEY_D    = 4'd13;
  localparam key_t KEY_STAR = 4'd14;
  localparam key_t KEY_HASH = 4'd15;

  // Scan results carry an extra top bit so "no key" is distinct from all 16 keys.
  typedef logic [4:0] scan_t;
  localparam scan_t KEY_NONE = 5'h10;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

  function automatic key_t key_at(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: return KEY_1;
      4'b00_01: return KEY_2;
      4'b00_10: return KEY_3;
      4'b00_11: return KEY_A;
      4'b01_00: return KEY_4;
      4'b01_01: return KEY_5;
      4'b01_10: return KEY_6;
      4'b01_11: return KEY_B;
      4'b10_00: return KEY_7;
      4'b10_01: return KEY_8;
      4'b10_10: return KEY_9;
      4'b10_11: return KEY_C;
      4'b11_00: return KEY_STAR;
      4'b11_01: return KEY_0;
      4'b11_10: return KEY_HASH;
      default:  return KEY_D;
    endcase
  endfunction

  function automatic logic is_digit(input key_t k);
    return k <= KEY_9;
  endfunction

endpackage

// File: rtl/key_entry_keypad_scan.sv
// 4x4 keypad column scanner with full-scan debounce; emits a one-cycle key
// event with its code when a press is accepted.
module keypad_scan
  import key_entry_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output key_t       key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       hits;
  scan_t            acc_key;
  logic             held;
  scan_t            last_key;
  logic [DEB_W-1:0] deb_cnt;

  logic             sample;
  logic             scan_done;
  logic [2:0]       row_hits;
  logic [1:0]       row_sel;
  logic [1:0]       hits_next;
  scan_t            key_next;
  scan_t            scan_result;
  logic [DEB_W-1:0] deb_inc;
  logic [DEB_W-1:0] run_len;
  logic             hit_limit;

  assign col = ~(4'b0001 << col_idx);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    row_hits = '0;
    row_sel  = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) begin
        row_hits = row_hits + 3'd1;
        row_sel  = 2'(r);
      end
    end

    // Column 0 starts a fresh scan; crossings saturate at 2 ("multiple").
    hits_next = (col_idx == 2'd0) ? 2'd0 : hits;
    key_next  = (col_idx == 2'd0) ? KEY_NONE : acc_key;
    if (row_hits == 3'd1) begin
      hits_next = (hits_next == 2'd0) ? 2'd1 : 2'd2;
      key_next  = {1'b0, key_at(row_sel, col_idx)};
    end else if (row_hits > 3'd1) begin
      hits_next = 2'd2;
    end

    sample      = (div_cnt == DIV_LAST);
    scan_done   = sample && (col_idx == 2'd3);
    scan_result = (hits_next == 2'd1) ? key_next : KEY_NONE;
    deb_inc     = deb_cnt + DEB_W'(1);

    if (held)
      run_len = (scan_result == KEY_NONE) ? deb_inc : '0;
    else if (scan_result == KEY_NONE)
      run_len = '0;
    else
      run_len = (scan_result == last_key) ? deb_inc : DEB_W'(1);
    hit_limit = (run_len == DEB_W'(DEBOUNCE));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt   <= '0;
      col_idx   <= '0;
      hits      <= '0;
      acc_key   <= KEY_NONE;
      held      <= 1'b0;
      last_key  <= KEY_NONE;
      deb_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= 1'b0;
      if (sample) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        hits    <= hits_next;
        acc_key <= key_next;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (scan_done) begin
        if (hit_limit) begin
          deb_cnt  <= '0;
          last_key <= KEY_NONE;
          held     <= !held;
          if (!held) begin
            key_valid <= 1'b1;
            key_code  <= scan_result[3:0];
          end
        end else begin
          deb_cnt  <= run_len;
          last_key <= held ? KEY_NONE : scan_result;
        end
      end
    end
  end

endmodule

// File: rtl/key_entry.sv
// Three-digit guess entry: keypad scanner plus a small buffer FSM with
// backspace, clear and enter (digits must be pairwise distinct).
module key_entry
  import key_entry_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] iRow,
  output logic [3:0] oCol,
  output logic [3:0] oNum1,
  output logic [3:0] oNum2,
  output logic [3:0] oNum3,
  output logic       oNumRdy,
  output logic [1:0] oCount,
  output logic       oErr
);

  logic       key_valid;
  key_t       key_code;
  logic [1:0] state;
  logic [1:0] state_next;
  key_t       digit0, digit1, digit2;
  logic       wr_en;
  logic       load_nums;
  logic       rdy_next;
  logic       err_next;
  logic       distinct;

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .row       (iRow),
    .col       (oCol),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  assign oCount   = state;
  assign distinct = (digit0 != digit1) && (digit0 != digit2) && (digit1 != digit2);

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    load_nums  = 1'b0;
    rdy_next   = 1'b0;
    err_next   = 1'b0;
    if (key_valid) begin
      if (is_digit(key_code)) begin
        if (state != ST_FULL) begin
          wr_en      = 1'b1;
          state_next = state + 2'd1;
        end
      end else begin
        case (key_code)
          KEY_A:    if (state != ST_EMPTY) state_next = state - 2'd1;
          KEY_STAR: state_next = ST_EMPTY;
          KEY_HASH: begin
            if (state == ST_FULL && distinct) begin
              load_nums  = 1'b1;
              rdy_next   = 1'b1;
              state_next = ST_EMPTY;
            end else begin
              err_next = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_EMPTY;
      oNumRdy <= 1'b0;
      oErr    <= 1'b0;
      oNum1   <= '0;
      oNum2   <= '0;
      oNum3   <= '0;
    end else begin
      state   <= state_next;
      oNumRdy <= rdy_next;
      oErr    <= err_next;
      if (load_nums) begin
        oNum1 <= digit0;
        oNum2 <= digit1;
        oNum3 <= digit2;
      end
    end
  end

  // NOTE: the digit buffer is deliberately not reset; a slot is only read
  // after the FSM has written it, so reset logic here would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (state)
        ST_EMPTY: digit0 <= key_code;
        ST_ONE:   digit1 <= key_code;
        default:  digit2 <= key_code;
      endcase
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: a keypad model drives iRow from oCol and a
// queue-based entry model predicts oCount, oNumRdy/oErr pulses and oNum1..3.
module tb_key_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int SCAN     = 4 * SCAN_DIV;

  // Key numbering inside the bench: 0-9 digits, 10..13 = A..D, 14 = *, 15 = #
  localparam int K_A = 10, K_B = 11, K_STAR = 14, K_HASH = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] iRow, oCol, oNum1, oNum2, oNum3;
  logic       oNumRdy, oErr;
  logic [1:0] oCount;
  logic [15:0] pressed = '0;   // bit r*4+c: key at row r, column c is down

  int vectors = 0;
  int miscompares = 0;
  int rdy_cycles = 0;
  int err_cycles = 0;

  int q[$];
  int m_num[3] = '{0, 0, 0};

  key_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk     (clk),
    .reset   (reset),
    .iRow    (iRow),
    .oCol    (oCol),
    .oNum1   (oNum1),
    .oNum2   (oNum2),
    .oNum3   (oNum3),
    .oNumRdy (oNumRdy),
    .oCount  (oCount),
    .oErr    (oErr)
  );

  always #5 clk = ~clk;

  // Passive keypad: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    iRow = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !oCol[c]) iRow[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (oNumRdy) rdy_cycles++;
      if (oErr) err_cycles++;
      vectors++;
      if (!(oCol inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}) || (oNumRdy && oErr)) begin
        miscompares++;
        $display("FAIL col_or_pulse_overlap: oCol=%b rdy=%b err=%b, required one low column and no overlap",
                 oCol, oNumRdy, oErr);
      end
    end
  end

  function automatic int key_pos(input int k);
    if (k >= 1 && k <= 9) return ((k - 1) / 3) * 4 + (k - 1) % 3;
    case (k)
      0:       return 13;
      10:      return 3;
      11:      return 7;
      12:      return 11;
      13:      return 15;
      14:      return 12;
      default: return 14;
    endcase
  endfunction

  task automatic model_key(input int k, output bit exp_rdy, output bit exp_err);
    exp_rdy = 1'b0;
    exp_err = 1'b0;
    if (k <= 9) begin
      if (q.size() < 3) q.push_back(k);
    end else if (k == K_A) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (k == K_STAR) begin
      q.delete();
    end else if (k == K_HASH) begin
      if (q.size() == 3 && q[0] != q[1] && q[0] != q[2] && q[1] != q[2]) begin
        exp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) m_num[i] = q[i];
        q.delete();
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  // One press/release of key k, then the resulting outputs are compared.
  task automatic press_key(input int k, input int hold_cyc, input int rel_cyc, input string tag);
    bit er, ee;
    int r0, e0;
    model_key(k, er, ee);
    r0 = rdy_cycles;
    e0 = err_cycles;
    pressed = '0;
    pressed[key_pos(k)] = 1'b1;
    repeat (hold_cyc) @(negedge clk);
    pressed = '0;
    repeat (rel_cyc) @(negedge clk);
    vectors++;
    if (oCount !== 2'(q.size())) begin
      miscompares++;
      $display("FAIL %s count key=%0d: got %0d expected %0d", tag, k, oCount, q.size());
    end
    vectors++;
    if ((rdy_cycles - r0) != int'(er) || (err_cycles - e0) != int'(ee)) begin
      miscompares++;
      $display("FAIL %s pulses key=%0d: got rdy=%0d err=%0d expected rdy=%0d err=%0d",
               tag, k, rdy_cycles - r0, err_cycles - e0, er, ee);
    end
    vectors++;
    if ({oNum1, oNum2, oNum3} !== {4'(m_num[0]), 4'(m_num[1]), 4'(m_num[2])}) begin
      miscompares++;
      $display("FAIL %s nums key=%0d: got %0d%0d%0d expected %0d%0d%0d",
               tag, k, oNum1, oNum2, oNum3, m_num[0], m_num[1], m_num[2]);
    end
  endtask

  task automatic press_std(input int k, input string tag);
    press_key(k, 3 * SCAN + int'($urandom_range(0, SCAN)), 3 * SCAN + 4 + int'($urandom_range(0, SCAN)), tag);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (oCol !== 4'b1110 || oCount !== 2'd0 || oNumRdy !== 1'b0 || oErr !== 1'b0 ||
        {oNum1, oNum2, oNum3} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_values: got col=%b cnt=%0d rdy=%b err=%b nums=%h, expected 1110/0/0/0/000",
               oCol, oCount, oNumRdy, oErr, {oNum1, oNum2, oNum3});
    end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    press_std(1, "basic");
    press_std(2, "basic");
    press_std(3, "basic");
    press_std(K_HASH, "basic");
  endtask

  task automatic test_reject;
    press_std(5, "reject");
    press_std(5, "reject");
    press_std(7, "reject");
    press_std(K_HASH, "reject");
    press_std(K_STAR, "reject");
    press_std(9, "reject");
    press_std(8, "reject");
    press_std(0, "reject");
    press_std(K_HASH, "reject");
  endtask

  task automatic test_backspace;
    press_std(4, "backspace");
    press_std(K_A, "backspace");
    press_std(6, "backspace");
    press_std(0, "backspace");
    press_std(1, "backspace");
    press_std(K_HASH, "backspace");
    press_std(1, "fourth_digit");
    press_std(2, "fourth_digit");
    press_std(3, "fourth_digit");
    press_std(4, "fourth_digit");
    press_std(K_HASH, "fourth_digit");
  endtask

  task automatic test_long_hold;
    press_key(8, 20 * SCAN, 3 * SCAN + 8, "long_hold");
    press_std(K_STAR, "long_hold");
  endtask

  task automatic test_bounce;
    int r0, e0;
    r0 = rdy_cycles;
    e0 = err_cycles;
    for (int i = 0; i < 10; i++) begin
      pressed = '0;
      pressed[key_pos(5)] = (i % 2 == 0);
      repeat (SCAN) @(negedge clk);
    end
    pressed = '0;
    repeat (4 * SCAN) @(negedge clk);
    vectors++;
    if (oCount !== 2'(q.size()) || rdy_cycles != r0 || err_cycles != e0) begin
      miscompares++;
      $display("FAIL bounce: got cnt=%0d pulses=%0d expected cnt=%0d pulses=0",
               oCount, rdy_cycles - r0 + err_cycles - e0, q.size());
    end
  endtask

  task automatic test_simultaneous;
    pressed = '0;
    pressed[key_pos(2)] = 1'b1;
    pressed[key_pos(3)] = 1'b1;
    repeat (4 * SCAN) @(negedge clk);
    pressed = '0;
    repeat (4 * SCAN) @(negedge clk);
    vectors++;
    if (oCount !== 2'(q.size())) begin
      miscompares++;
      $display("FAIL simultaneous: got cnt=%0d expected %0d", oCount, q.size());
    end
  endtask

  task automatic test_reset_mid_debounce;
    int r0, e0;
    press_std(1, "pre_reset");
    press_std(2, "pre_reset");
    press_std(3, "pre_reset");
    press_std(K_HASH, "pre_reset");
    press_std(4, "pre_reset");
    pressed = '0;
    pressed[key_pos(7)] = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (oCol !== 4'b1110 || oCount !== 2'd0 || oNumRdy !== 1'b0 || oErr !== 1'b0 ||
        {oNum1, oNum2, oNum3} !== 12'h000) begin
      miscompares++;
      $display("FAIL mid_reset_values: got col=%b cnt=%0d rdy=%b err=%b nums=%h, expected 1110/0/0/0/000",
               oCol, oCount, oNumRdy, oErr, {oNum1, oNum2, oNum3});
    end
    reset = 1'b1;
    q.delete();
    m_num = '{0, 0, 0};
    r0 = rdy_cycles;
    e0 = err_cycles;
    repeat (8) @(negedge clk);
    vectors++;
    if (oCount !== 2'd0) begin
      miscompares++;
      $display("FAIL held_across_reset: got cnt=%0d expected 0", oCount);
    end
    repeat (3 * SCAN) @(negedge clk);
    q.push_back(7);
    vectors++;
    if (oCount !== 2'd1) begin
      miscompares++;
      $display("FAIL fresh_press_after_reset: got cnt=%0d expected 1", oCount);
    end
    pressed = '0;
    repeat (3 * SCAN + 8) @(negedge clk);
    vectors++;
    if (rdy_cycles != r0 || err_cycles != e0 || {oNum1, oNum2, oNum3} !== 12'h000) begin
      miscompares++;
      $display("FAIL after_reset_quiet: got pulses=%0d nums=%h expected 0 and 000",
               rdy_cycles - r0 + err_cycles - e0, {oNum1, oNum2, oNum3});
    end
  endtask

  task automatic test_random;
    int k;
    press_std(K_STAR, "random");
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 15));
      if (k == K_B && ($urandom_range(0, 1) == 0)) k = int'($urandom_range(0, 9));
      press_std(k, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_backspace();
    test_long_hold();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
